// File: rtl/cpu_pkg.sv
// Shared core types: address/instruction words, fetch FSM states and reset defaults.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] instr_t;

    localparam addr_t  RESET_PC  = 32'h0000_0000;
    localparam instr_t NOP_INSTR = 32'h0000_0013;
    localparam addr_t  PC_STEP   = 32'h0000_0004;
    localparam addr_t  WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    // Fetched instruction together with the PC it was read from.
    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_slot_t;

    function automatic addr_t align_word(input addr_t a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selection (sequential vs. redirect target) and the slot's pc+4 adder.
module pc_next
    import cpu_pkg::*;
(
    input  addr_t pc_q_i,
    input  addr_t slot_pc_i,
    input  logic  pc_src_i,
    input  addr_t pc_target_i,
    output addr_t next_pc_o,
    output addr_t pc_plus4_o
);

    assign next_pc_o  = pc_src_i ? align_word(pc_target_i) : addr_t'(pc_q_i + PC_STEP);
    assign pc_plus4_o = addr_t'(slot_pc_i + PC_STEP);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem handshake and output slot.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        id_ready_i,
    input  logic        pc_src_i,
    input  logic [31:0] pc_target_i
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         valid_q, valid_d;
    fetch_slot_t  slot_q, slot_d;

    addr_t next_pc;
    logic  imem_req_c;
    logic  consume_c;

    pc_next u_pc_next (
        .pc_q_i      (pc_q),
        .slot_pc_i   (slot_q.pc),
        .pc_src_i    (pc_src_i),
        .pc_target_i (pc_target_i),
        .next_pc_o   (next_pc),
        .pc_plus4_o  (pc_plus4_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RESET;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            slot_q  <= '{pc: RESET_PC, instr: NOP_INSTR};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        slot_d     = slot_q;
        imem_req_c = 1'b0;
        consume_c  = valid_q && id_ready_i;

        if (consume_c) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            RESET: begin
                state_d = REQ;
                if (pc_src_i) begin
                    pc_d = next_pc;
                end
            end
            REQ: begin
                imem_req_c = !valid_q || id_ready_i;
                if (imem_req_c && imem_gnt_i) begin
                    state_d = WAIT;
                end
                // A redirect granted this cycle leaves a stale response in flight.
                if (pc_src_i) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    kill_d  = imem_req_c && imem_gnt_i;
                end
            end
            WAIT: begin
                if (pc_src_i) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    state_d = REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        slot_d.pc    = pc_q;
                        slot_d.instr = imem_rdata_i;
                        valid_d      = 1'b1;
                        pc_d         = next_pc;
                    end
                end
            end
            default: begin
                state_d = RESET;
            end
        endcase

        // An empty slot always presents a NOP downstream.
        if (!valid_d) begin
            slot_d.instr = NOP_INSTR;
        end
    end

    assign imem_req_o    = imem_req_c;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = slot_q.instr;
    assign pc_o          = slot_q.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized scoreboard run.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        id_ready = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .id_ready_i    (id_ready),
        .pc_src_i      (pc_src),
        .pc_target_i   (pc_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Instruction memory: grant policy from stimulus, rvalid m_lat cycles after a grant.
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 1;
    bit          rand_lat = 1'b0;
    bit          poison = 1'b0;
    logic [31:0] m_data = 32'h0;

    always begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (m_pend) begin
            if (m_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = m_data;
                m_pend      = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        #3;
        if (imem_req && imem_gnt) begin
            m_pend = 1'b1;
            m_cnt  = rand_lat ? int'($urandom_range(1, 3)) : m_lat;
            m_data = poison ? 32'hDEAD_BEEF : mem_word(imem_addr);
        end
    end

    // Reference model and scoreboard: expected slot contents pushed on accepted responses.
    fetch_slot_t sb[$];
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] fl_addr = 32'h0;
    bit          fl = 1'b0;
    bit          fl_kill = 1'b0;
    bit          prev_hold = 1'b0;

    always begin
        fetch_slot_t e;
        @(negedge clk);
        #3;
        if (rst) begin
            exp_pc    = RESET_PC;
            fl        = 1'b0;
            fl_kill   = 1'b0;
            prev_hold = 1'b0;
            sb.delete();
        end else begin
            if (instr_valid) begin
                if (id_ready) begin
                    check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("slot_pc", pc, e.pc);
                        check("slot_instr", instr, e.instr);
                        check("slot_pc_plus4", pc_plus4, e.pc + 32'd4);
                    end
                end else if (pc_src && sb.size() != 0) begin
                    void'(sb.pop_front());
                end
            end else begin
                check("nop_when_empty", instr, NOP_INSTR);
            end
            if (prev_hold) check("req_holds", 32'(imem_req), 32'd1);
            if (fl) check("no_req_in_wait", 32'(imem_req), 32'd0);

            if (fl && imem_rvalid) begin
                if (!fl_kill && !pc_src) begin
                    sb.push_back('{pc: fl_addr, instr: imem_rdata});
                    exp_pc = fl_addr + 32'd4;
                end
                fl      = 1'b0;
                fl_kill = 1'b0;
            end
            if (imem_req && imem_gnt) begin
                check("grant_addr", imem_addr, exp_pc);
                fl      = 1'b1;
                fl_addr = imem_addr;
                fl_kill = pc_src;
            end else if (fl && pc_src) begin
                fl_kill = 1'b1;
            end
            if (pc_src) exp_pc = pc_target & 32'hFFFF_FFFC;
            prev_hold = imem_req && !imem_gnt && !pc_src;
        end
    end

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (imem_req) break;
        end
        check("wait_req", 32'(imem_req), 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) break;
        end
        check("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] saved_instr;
        logic [31:0] saved_pc;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_pc", pc, RESET_PC);
        check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);

        // Reset release: first instruction after three edges.
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            #1;
            if (instr_valid) begin
                lat = i;
                break;
            end
        end
        check("first_valid_latency", 32'(lat), 32'd3);
        check("first_pc", pc, 32'h0);
        check("first_pc_plus4", pc_plus4, 32'h4);
        check("first_instr", instr, 32'h0050_0093);

        // Downstream stall holds the slot and suppresses requests.
        saved_instr = instr;
        saved_pc    = pc;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_instr", instr, saved_instr);
            check("stall_pc", pc, saved_pc);
            @(negedge clk);
            #1;
        end
        id_ready = 1'b1;
        poison   = 1'b1;
        m_lat    = 3;
        #1;
        check("release_req", 32'(imem_req), 32'd1);
        check("release_addr", imem_addr, 32'h4);

        // Redirect while waiting: the in-flight response must be dropped.
        @(negedge clk);
        pc_src    = 1'b1;
        pc_target = 32'h0000_0103;
        #1;
        check("redir_wait_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        pc_src = 1'b0;
        poison = 1'b0;
        m_lat  = 1;
        #1;
        check("kill_set", 32'(dut.kill_q), 32'd1);
        check("redir_wait_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        check("killed_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        #1;
        check("killed_dropped", 32'(instr_valid), 32'd0);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        check("kill_cleared", 32'(dut.kill_q), 32'd0);

        // Redirect coincident with rvalid: data dropped, no kill left behind.
        @(negedge clk);
        pc_src    = 1'b1;
        pc_target = 32'h0000_0040;
        @(negedge clk);
        pc_src = 1'b0;
        #1;
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h0000_0040);
        check("coinc_kill", 32'(dut.kill_q), 32'd0);
        check("coinc_valid", 32'(instr_valid), 32'd0);
        wait_valid();
        check("coinc_pc", pc, 32'h0000_0040);
        check("coinc_instr", instr, mem_word(32'h0000_0040));

        // PC wrap at the top of the address space, via a retargeted request.
        wait_req();
        pc_src    = 1'b1;
        pc_target = 32'hFFFF_FFFE;
        imem_gnt  = 1'b0;
        @(negedge clk);
        pc_src   = 1'b0;
        imem_gnt = 1'b1;
        #1;
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid();
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);

        // Reset mid-WAIT with a stale response arriving during RESET.
        wait_req();
        poison = 1'b1;
        m_lat  = 2;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        poison = 1'b0;
        m_lat  = 1;
        #1;
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_instr", instr, NOP_INSTR);
        check("mid_rst_pc", pc, RESET_PC);
        check("mid_rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        @(negedge clk);
        #1;
        check("restart_valid", 32'(instr_valid), 32'd0);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, RESET_PC);
        wait_valid();
        check("restart_pc", pc, RESET_PC);
        check("restart_instr", instr, 32'h0050_0093);

        // Randomized traffic: stalls, grant gaps, variable latency, redirects.
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            id_ready  = ($urandom_range(0, 3) != 0);
            imem_gnt  = ($urandom_range(0, 1) == 1);
            pc_src    = ($urandom_range(0, 19) == 0);
            pc_target = $urandom;
        end
        @(negedge clk);
        pc_src   = 1'b0;
        id_ready = 1'b1;
        imem_gnt = 1'b1;
        repeat (10) @(negedge clk);
        #5;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RISC-V core, directly upstream of the control decoder. Holds the program counter, issues one-outstanding-request reads to instruction memory over a req/gnt/rvalid handshake, and presents the fetched word with its PC in an output slot. The decode/control stage consumes the slot with a ready handshake and returns a taken-branch/jump redirect (`pc_src`, `pc_target`) that flushes the slot and any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `NOP_INSTR`, 32'h0000_0013: `addi x0,x0,0`, driven on `instr` whenever the slot is empty.

- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: byte address of the request, bits [1:0] always 00.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid, ≥1 cycle after gnt, cannot be stalled.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: output slot holds a valid instruction.
- `instr` out 32: slot instruction; `NOP_INSTR` when empty.
- `pc` out 32: PC of slot instruction.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32.
- `id_ready` in 1: downstream accepts the slot this cycle (consume = `instr_valid && id_ready`).
- `pc_src` in 1: redirect request, from the control stage's PCsrc.
- `pc_target` in 32: redirect target; bits [1:0] ignored (forced 00).

## Operation
- State `pc_q` (next PC to fetch), `kill_q` (discard pending response), slot registers, and FSM with states RESET, REQ and WAIT.
- RESET: entered while `rst`=1. Outputs: `imem_req`=0, `instr_valid`=0, `instr`=`NOP_INSTR`, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`. Internal: `pc_q`=`RESET_PC`, `kill_q`=0. Moves to REQ on the first cycle with `rst`=0.
- REQ:
  - `imem_req` = slot empty or being consumed this cycle.
  - `imem_addr` = `pc_q`.
  - Once asserted, `imem_req` holds until gnt unless a redirect occurs.
  - On `imem_req && imem_gnt` the FSM moves to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - If `kill_q`=1: drop the data, clear `kill_q`, go to REQ.
  - Otherwise: load the slot (`instr`=rdata, `pc`=`pc_q`), set `instr_valid`, set `pc_q`=`pc_q`+4, go to REQ.
- Consume: `instr_valid && id_ready` clears `instr_valid` unless the slot is reloaded the same cycle.
- Redirect (`pc_src`=1) has priority over all other events:
  - `pc_q` <= `{pc_target[31:2],2'b00}`, and `instr_valid` clears.
  - In WAIT without rvalid: set `kill_q`, stay in WAIT.
  - In WAIT with rvalid: drop the data, go to REQ.
  - In REQ with gnt the same cycle: go to WAIT with `kill_q`=1.
  - In REQ without gnt: stay in REQ; the request may be retargeted next cycle.
- Arithmetic: all PC sums are 32-bit and wrap; 32'hFFFF_FFFC + 4 = 0.
- `rst` asserted in any state, including mid-WAIT, returns the block to RESET. A late rvalid from before reset is ignored, because RESET ignores rvalid and the first post-reset request restarts the handshake.

## Timing
- Zero-wait memory (gnt same cycle, rvalid next cycle):
  - First `instr_valid` 3 cycles after `rst` deasserts.
  - Throughput: 1 instruction per 2 cycles when `id_ready`=1 continuously.
- Redirect latency: the target's request is on `imem_addr` one cycle after `pc_src`, or after the killed response returns if a fetch was in flight.
- Slot outputs are registered. `imem_req` depends combinationally on `id_ready` and slot state only. No combinational path from `imem_rdata` to outputs.
- Slot outputs stay stable while `instr_valid && !id_ready`.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_INSTR` and `RESET_PC` defaults.
  - `fetch_state_t` enum {RESET, REQ, WAIT}.
  - The 32-bit `addr_t`/`instr_t` typedefs also used by control.
- One sub-module, `pc_next`: combinational next-PC mux (`pc_q+4` vs aligned `pc_target`) plus the `pc_plus4` adder. The FSM, kill flag and slot stay in `fetch_stage`.

## Test plan
- Reset release, memory returns 32'h00500093 at 0x0 (gnt immediate, rvalid +1) → first `instr_valid` 3 cycles after `rst` deasserts with `pc`=0x0, `pc_plus4`=0x4; next `imem_addr`=0x4.
- `id_ready`=0 for 5 cycles with a valid slot → `imem_req`=0, slot stable. Raise `id_ready` → request for next PC the same cycle.
- `pc_src`=1, `pc_target`=0x103 while in WAIT, rvalid arrives 2 cycles later with 0xDEADBEEF → response dropped, `instr_valid` stays 0, next `imem_addr`=0x100.
- `pc_src` and `imem_rvalid` in the same cycle, target 0x40 → data dropped, next request to 0x40; `kill_q` stays 0.
- `pc_q`=0xFFFF_FFFC fetch completes → `pc_plus4`=0x0, next `imem_addr`=0x0.
- `rst` pulsed mid-WAIT, then a stale rvalid → outputs at reset values, stale data never appears, fetch restarts at `RESET_PC`.
